pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- five-stage pipeline hazard / stall / trap controller
//
// Purpose:
//   Produces the per-stage clock enables and flushes for an IF/ID/EX/MEM/WB
//   pipeline. It handles EX-stage exceptions (flush and redirect to the trap
//   vector), data-memory wait states with a bus-error timeout, taken branches
//   and load-use stalls. Enables and flushes are combinational from the current
//   state and inputs. The redirect, the bus error and the wait counter are
//   registered.
//
// Ports:
//   i_clk               clock
//   i_rst_n             asynchronous active-low reset
//   i_exception_code_e  EX-stage exception code, 4'b1111 = none
//   i_trap_pc           trap vector target (XW bits)
//   i_mem_req_m         MEM-stage instruction accesses data memory
//   i_mem_ack           data memory completes the access this cycle
//   i_load_use_haz      ID instruction needs a load result from EX
//   i_branch_taken_e    EX branch/jump taken
//   o_pc_en .. o_mem_wb_en              stage clock enables
//   o_if_id_flush .. o_ex_mem_flush     stage flushes
//   o_redirect_valid / o_redirect_pc    PC redirect to the trap vector
//   o_bus_err           one-cycle memory-timeout pulse
//   o_state             RUN=00, MEM_WAIT=01, TRAP_FLUSH=10
// -----------------------------------------------------------------------------

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module pipe_ctrl #(
  parameter int XLEN        = `XLEN_64b,
  parameter int MEM_TIMEOUT = 15,
  localparam int XW         = 1 << (XLEN + 4)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_exception_code_e,
  input  logic [XW-1:0] i_trap_pc,
  input  logic          i_mem_req_m,
  input  logic          i_mem_ack,
  input  logic          i_load_use_haz,
  input  logic          i_branch_taken_e,
  output logic          o_pc_en,
  output logic          o_if_id_en,
  output logic          o_id_ex_en,
  output logic          o_ex_mem_en,
  output logic          o_mem_wb_en,
  output logic          o_if_id_flush,
  output logic          o_id_ex_flush,
  output logic          o_ex_mem_flush,
  output logic          o_redirect_valid,
  output logic [XW-1:0] o_redirect_pc,
  output logic          o_bus_err,
  output logic [1:0]    o_state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // Counter value seen in the last MEM_WAIT cycle before a timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [3:0] EXC_NONE = 4'b1111;

  // Bit positions inside the packed enable / flush vectors.
  localparam int EN_PC     = 4;
  localparam int EN_IF_ID  = 3;
  localparam int EN_ID_EX  = 2;
  localparam int EN_EX_MEM = 1;
  localparam int EN_MEM_WB = 0;
  localparam int FL_IF_ID  = 2;
  localparam int FL_ID_EX  = 1;
  localparam int FL_EX_MEM = 0;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_MEM_WAIT   = 2'b01,
    ST_TRAP_FLUSH = 2'b10
  } state_e;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [XW-1:0]    redirect_pc_reg, redirect_pc_next;
  logic             redirect_valid_reg, redirect_valid_next;
  logic             bus_err_reg, bus_err_next;

  logic [4:0]       en_next;
  logic [2:0]       flush_next;
  logic [4:0]       en_gated;
  logic [2:0]       flush_gated;

  logic             exc_e;
  logic             mem_stall;
  logic             wait_timeout;

  assign exc_e        = (i_exception_code_e != EXC_NONE);
  assign mem_stall    = i_mem_req_m & ~i_mem_ack;
  assign wait_timeout = (cnt_reg == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register plus registered redirect, bus-error pulse and wait counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg          <= ST_RUN;
      cnt_reg            <= '0;
      redirect_pc_reg    <= '0;
      redirect_valid_reg <= 1'b0;
      bus_err_reg        <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      redirect_pc_reg    <= redirect_pc_next;
      redirect_valid_reg <= redirect_valid_next;
      bus_err_reg        <= bus_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and same-cycle enables / flushes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    redirect_pc_next = redirect_pc_reg;
    bus_err_next     = 1'b0;
    en_next          = 5'b11111;
    flush_next       = 3'b000;

    case (state_reg)
      ST_MEM_WAIT: begin
        // The pipe is frozen. Exceptions and hazards are ignored because the
        // stalled EX instruction presents them again once the pipe moves.
        if (i_mem_ack) begin
          // Ack wins over a coincident timeout: the access completed.
          state_next = ST_RUN;
        end else if (wait_timeout) begin
          en_next                = 5'b00000;
          flush_next[FL_EX_MEM]  = 1'b1;
          redirect_pc_next       = i_trap_pc;
          bus_err_next           = 1'b1;
          state_next             = ST_TRAP_FLUSH;
        end else begin
          en_next = 5'b00000;
          // Saturate so the counter can never wrap back into a live range.
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      ST_TRAP_FLUSH: begin
        // Single cycle in which the redirect is visible. Kill the wrong-path
        // fetch that is sitting in IF/ID.
        flush_next[FL_IF_ID] = 1'b1;
        state_next           = ST_RUN;
      end

      default: begin
        // RUN. The unreachable encoding 2'b11 behaves exactly like RUN.
        state_next = ST_RUN;
        if (exc_e) begin
          flush_next       = 3'b111;
          redirect_pc_next = i_trap_pc;
          state_next       = ST_TRAP_FLUSH;
        end else if (mem_stall) begin
          en_next    = 5'b00000;
          cnt_next   = '0;
          state_next = ST_MEM_WAIT;
        end else if (i_branch_taken_e) begin
          // A taken branch already discards the younger instructions, so a
          // coincident load-use stall would only waste a cycle.
          flush_next[FL_IF_ID] = 1'b1;
          flush_next[FL_ID_EX] = 1'b1;
        end else if (i_load_use_haz) begin
          // Hold PC and IF/ID. Insert a bubble into EX.
          en_next[EN_PC]       = 1'b0;
          en_next[EN_IF_ID]    = 1'b0;
          flush_next[FL_ID_EX] = 1'b1;
        end
      end
    endcase

    redirect_valid_next = (state_next == ST_TRAP_FLUSH);
  end

  // ---------------------------------------------------------------------------
  // While reset is asserted every enable and flush is held low immediately,
  // without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_en_gate
      assign en_gated[gi] = en_next[gi] & i_rst_n;
    end
    for (gi = 0; gi < 3; gi++) begin : g_flush_gate
      assign flush_gated[gi] = flush_next[gi] & i_rst_n;
    end
  endgenerate

  assign o_pc_en          = en_gated[EN_PC];
  assign o_if_id_en       = en_gated[EN_IF_ID];
  assign o_id_ex_en       = en_gated[EN_ID_EX];
  assign o_ex_mem_en      = en_gated[EN_EX_MEM];
  assign o_mem_wb_en      = en_gated[EN_MEM_WB];
  assign o_if_id_flush    = flush_gated[FL_IF_ID];
  assign o_id_ex_flush    = flush_gated[FL_ID_EX];
  assign o_ex_mem_flush   = flush_gated[FL_EX_MEM];

  assign o_redirect_valid = redirect_valid_reg;
  assign o_redirect_pc    = redirect_pc_reg;
  assign o_bus_err        = bus_err_reg;
  assign o_state          = state_reg;

endmodule
